// File: rtl/bp_update_ctrl_if.sv
// Signal bundle between bp_update_ctrl, the fetch/execute stages and the
// external branch-history cache (2 read ports, 1 write port).
interface bp_update_ctrl_if #(
    parameter int unsigned PC_WIDTH = 32
);
    // fetch-side prediction
    logic [PC_WIDTH-1:0] pred_pc;
    logic                pred_taken;
    logic                pred_hit;
    // execute-side resolved-branch updates
    logic                upd_valid;
    logic [PC_WIDTH-1:0] upd_pc;
    logic                upd_taken;
    logic                upd_ready;
    logic                busy;
    // cache ports
    logic [PC_WIDTH-1:0] c_ra0;
    logic [1:0]          c_dout0;
    logic                c_hit0;
    logic [PC_WIDTH-1:0] c_ra1;
    logic [1:0]          c_dout1;
    logic                c_hit1;
    logic [PC_WIDTH-1:0] c_wa;
    logic [1:0]          c_din;
    logic                c_we;

    modport slave (
        input  pred_pc, upd_valid, upd_pc, upd_taken,
               c_dout0, c_hit0, c_dout1, c_hit1,
        output pred_taken, pred_hit, upd_ready, busy,
               c_ra0, c_ra1, c_wa, c_din, c_we
    );

    modport master (
        output pred_pc, upd_valid, upd_pc, upd_taken,
               c_dout0, c_hit0, c_dout1, c_hit1,
        input  pred_taken, pred_hit, upd_ready, busy,
               c_ra0, c_ra1, c_wa, c_din, c_we
    );
endinterface

// File: rtl/bp_update_ctrl.sv
// Branch-history cache sequencer: combinational prediction on read port 0, queued
// read-modify-write of 2-bit counters on read port 1 + write port. Optional macro BP_FWD_EN.
module bp_update_ctrl #(
    parameter int unsigned PC_WIDTH  = 32,
    parameter int unsigned UPD_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    bp_update_ctrl_if.slave bus
);
    localparam int unsigned AW = $clog2(UPD_DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        COMMIT = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [PC_WIDTH-1:0] q_pc_q [UPD_DEPTH];
    logic [UPD_DEPTH-1:0] q_taken_q;
    logic [AW:0]         wr_ptr_q, wr_ptr_d;
    logic [AW:0]         rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]       wr_idx, rd_idx;
    logic                empty, full, push, pop;
    logic [PC_WIDTH-1:0] work_pc_q, work_pc_d;
    logic                work_taken_q, work_taken_d;
    logic [1:0]          ctr_q, ctr_d;
    logic [PC_WIDTH-1:0] work_addr;

    function automatic logic [1:0] ctr_next(input logic hit, input logic [1:0] ctr,
                                            input logic taken);
        logic [1:0] r;
        if (!hit)
            r = taken ? 2'b10 : 2'b01;
        else if (taken)
            r = (ctr == 2'b11) ? ctr : ctr + 2'd1;
        else
            r = (ctr == 2'b00) ? ctr : ctr - 2'd1;
        return r;
    endfunction

    // Update queue: extra pointer bit distinguishes full from empty
    assign wr_idx = wr_ptr_q[AW-1:0];
    assign rd_idx = rd_ptr_q[AW-1:0];
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);
    assign push   = bus.upd_valid && !full;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_pc_q[wr_idx]    <= bus.upd_pc;
            q_taken_q[wr_idx] <= bus.upd_taken;
        end
    end

    always_comb begin
        state_d      = state_q;
        work_pc_d    = work_pc_q;
        work_taken_d = work_taken_q;
        ctr_d        = ctr_q;
        pop          = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop          = 1'b1;
                    work_pc_d    = q_pc_q[rd_idx];
                    work_taken_d = q_taken_q[rd_idx];
                    state_d      = LOOKUP;
                end
            end
            LOOKUP: begin
                ctr_d   = ctr_next(bus.c_hit1, bus.c_dout1, work_taken_q);
                state_d = COMMIT;
            end
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            work_pc_q    <= '0;
            work_taken_q <= 1'b0;
            ctr_q        <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            work_pc_q    <= work_pc_d;
            work_taken_q <= work_taken_d;
            ctr_q        <= ctr_d;
        end
    end

    assign work_addr     = work_pc_q >> 2;
    assign bus.c_ra0     = bus.pred_pc >> 2;
    assign bus.c_ra1     = work_addr;
    assign bus.c_wa      = work_addr;
    assign bus.c_din     = ctr_q;
    assign bus.c_we      = (state_q == COMMIT);
    assign bus.upd_ready = !full;
    assign bus.busy      = !empty || (state_q != IDLE);

`ifdef BP_FWD_EN
    // Fetch sees the counter being written this cycle instead of the stale cache value
    always_comb begin
        bus.pred_hit   = bus.c_hit0;
        bus.pred_taken = bus.c_hit0 & bus.c_dout0[1];
        if ((state_q == COMMIT) && (bus.c_ra0 == work_addr)) begin
            bus.pred_hit   = 1'b1;
            bus.pred_taken = ctr_q[1];
        end
    end
`else
    assign bus.pred_hit   = bus.c_hit0;
    assign bus.pred_taken = bus.c_hit0 & bus.c_dout0[1];
`endif

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Directed bench for bp_update_ctrl with a behavioural 2R/1W cache model
// and a negedge monitor that records every cache write.
`timescale 1ns/1ps
module tb_bp_update_ctrl;
    localparam int unsigned PW = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bp_update_ctrl_if #(.PC_WIDTH(PW)) bus ();

    bp_update_ctrl #(.PC_WIDTH(PW), .UPD_DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // cache model indexed by low 10 address bits; test addresses never alias
    logic [1:0] c_data [1024];
    logic       c_vld  [1024];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 1024; i++) begin
                c_vld[i]  <= 1'b0;
                c_data[i] <= 2'b00;
            end
        end else if (bus.c_we) begin
            c_vld[bus.c_wa[9:0]]  <= 1'b1;
            c_data[bus.c_wa[9:0]] <= bus.c_din;
        end
    end
    assign bus.c_hit0  = c_vld[bus.c_ra0[9:0]];
    assign bus.c_dout0 = c_data[bus.c_ra0[9:0]];
    assign bus.c_hit1  = c_vld[bus.c_ra1[9:0]];
    assign bus.c_dout1 = c_data[bus.c_ra1[9:0]];

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] cm_wa  [$];
    logic [1:0]  cm_din [$];
    int unsigned cm_cyc [$];
    always @(negedge clk) begin
        if (!reset && bus.c_we) begin
            cm_wa.push_back(bus.c_wa);
            cm_din.push_back(bus.c_din);
            cm_cyc.push_back(cyc);
        end
    end

    int unsigned n_chk = 0;
    int unsigned n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] pc, input logic tk, output int unsigned acc);
        int unsigned g = 0;
        bus.upd_valid = 1'b1;
        bus.upd_pc    = pc;
        bus.upd_taken = tk;
        while (!bus.upd_ready && g < 50) begin
            tick();
            g++;
        end
        chk("send_ready", 32'(bus.upd_ready), 32'd1);
        tick();
        acc = cyc;
        bus.upd_valid = 1'b0;
    endtask

    task automatic wait_commits(input int unsigned n);
        int unsigned g = 0;
        while (cm_wa.size() < n && g < 100) begin
            tick();
            g++;
        end
        chk("commit_count", cm_wa.size(), n);
    endtask

    task automatic drain;
        int unsigned g = 0;
        while (bus.busy && g < 100) begin
            tick();
            g++;
        end
        tick();
        chk("drain_idle", 32'(bus.busy), 32'd0);
    endtask

    task automatic clear_log;
        cm_wa.delete();
        cm_din.delete();
        cm_cyc.delete();
    endtask

    logic [1:0]  t2_exp [9];
    int unsigned acc;
    int unsigned acc_n;
    logic        rdy;
    logic        fwd_exp;

    initial begin
        bus.pred_pc   = '0;
        bus.upd_valid = 1'b0;
        bus.upd_pc    = '0;
        bus.upd_taken = 1'b0;
        reset = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_busy",  32'(bus.busy),      32'd0);
        chk("rst_ready", 32'(bus.upd_ready), 32'd1);
        chk("rst_we",    32'(bus.c_we),      32'd0);
        chk("rst_hit",   32'(bus.pred_hit),  32'd0);
        tick();
        reset = 1'b0;

        // 1: allocate taken at 0x100, then predict from it
        clear_log();
        bus.pred_pc = 32'h100;
        send(32'h100, 1'b1, acc);
        @(negedge clk);
        chk("t1_pre_hit", 32'(bus.pred_hit), 32'd0);
        wait_commits(1);
        chk("t1_lat", cm_cyc[0] - acc, 32'd2);   // write lands on edge acc+3
        chk("t1_wa",  cm_wa[0],  32'h40);
        chk("t1_din", 32'(cm_din[0]), 32'd2);
        @(negedge clk);
        chk("t1_hit",   32'(bus.pred_hit),   32'd1);
        chk("t1_taken", 32'(bus.pred_taken), 32'd1);
        drain();

        // 2: saturation up and down on one PC, queued back-to-back
        clear_log();
        t2_exp = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00};
        send(32'h200, 1'b1, acc);
        for (int k = 0; k < 4; k++) send(32'h200, 1'b1, acc);
        for (int k = 0; k < 4; k++) send(32'h200, 1'b0, acc);
        wait_commits(9);
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("t2_din%0d", i), 32'(cm_din[i]), 32'(t2_exp[i]));
            chk($sformatf("t2_wa%0d", i), cm_wa[i], 32'h80);
        end
        chk("t2_gap", cm_cyc[8] - cm_cyc[7], 32'd3);
        drain();

        // 3: valid held 8 cycles; queue fills after the 6th accept
        clear_log();
        acc_n = 0;
        bus.upd_valid = 1'b1;
        bus.upd_taken = 1'b1;
        for (int k = 0; k < 8; k++) begin
            bus.upd_pc = 32'h1000 + acc_n * 4;
            if (k == 5) chk("t3_ready_k5", 32'(bus.upd_ready), 32'd1);
            if (k == 6) chk("t3_ready_k6", 32'(bus.upd_ready), 32'd0);
            rdy = bus.upd_ready;
            tick();
            if (rdy) acc_n++;
        end
        bus.upd_valid = 1'b0;
        chk("t3_accepts", acc_n, 32'd6);
        wait_commits(6);
        drain();
        chk("t3_total", cm_wa.size(), 32'd6);
        for (int i = 0; i < 6; i++)
            chk($sformatf("t3_wa%0d", i), cm_wa[i], 32'h400 + 32'(i));

        // 4: reset while in LOOKUP with two entries still queued
        clear_log();
        for (int k = 0; k < 4; k++) send(32'h700 + 32'(k) * 4, 1'b1, acc);
        tick();
        chk("t4_pre_busy", 32'(bus.busy), 32'd1);
        chk("t4_pre_we",   32'(bus.c_we), 32'd0);
        chk("t4_pre_cnt",  cm_wa.size(),  32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("t4_busy",  32'(bus.busy),      32'd0);
        chk("t4_ready", 32'(bus.upd_ready), 32'd1);
        chk("t4_we",    32'(bus.c_we),      32'd0);
        repeat (10) tick();
        chk("t4_no_commit", cm_wa.size(), 32'd1);
        chk("t4_idle",      32'(bus.busy), 32'd0);

        // 5: same-PC prediction during COMMIT (cache 01, writing 10)
        clear_log();
        bus.pred_pc = 32'h600;
        send(32'h600, 1'b0, acc);
        wait_commits(1);
        chk("t5_alloc", 32'(cm_din[0]), 32'd1);
        drain();
        send(32'h600, 1'b1, acc);
        tick();
        tick();
        @(negedge clk);
`ifdef BP_FWD_EN
        fwd_exp = 1'b1;
`else
        fwd_exp = 1'b0;
`endif
        chk("t5_we",    32'(bus.c_we),       32'd1);
        chk("t5_din",   32'(bus.c_din),      32'd2);
        chk("t5_hit",   32'(bus.pred_hit),   32'd1);
        chk("t5_taken", 32'(bus.pred_taken), 32'(fwd_exp));
        drain();
        chk("t5_after", 32'(bus.pred_taken), 32'd1);

        // 6: miss not-taken at 0x300 while fetch looks at neighbouring 0x304
        clear_log();
        bus.pred_pc = 32'h304;
        send(32'h300, 1'b0, acc);
        tick();
        tick();
        @(negedge clk);
        chk("t6_we",    32'(bus.c_we),       32'd1);
        chk("t6_wa",    bus.c_wa,            32'hC0);
        chk("t6_din",   32'(bus.c_din),      32'd1);
        chk("t6_hit",   32'(bus.pred_hit),   32'd0);
        chk("t6_taken", 32'(bus.pred_taken), 32'd0);
        drain();
        chk("t6_hit_after", 32'(bus.pred_hit), 32'd0);
        bus.pred_pc = 32'h300;
        @(negedge clk);
        chk("t6_hit300",   32'(bus.pred_hit),   32'd1);
        chk("t6_taken300", 32'(bus.pred_taken), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
